// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi traceback scheduler slice.
// Holds the scheduler state encoding, trellis width, default window sizes and the pointer wrap helper.
package viterbi_pkg;

  localparam int unsigned STATE_W   = 2;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned BLOCK_DEF = 8;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_TRACE = 2'd1,
    S_FLUSH = 2'd2
  } sched_state_e;

  // Descending step through a circular buffer of mem entries.
  function automatic int unsigned addr_dec(input int unsigned a, input int unsigned mem);
    return (a == 0) ? mem - 1 : a - 1;
  endfunction

endpackage

// File: rtl/viterbi_tb_sched_if.sv
// ACS / survivor-memory / TBU signal bundle seen by the traceback scheduler.
// The master modport is the scheduler side; slave is the surrounding datapath.
interface viterbi_tb_sched_if
  import viterbi_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
);
  logic               acs_valid_i;
  logic               acs_ready_o;
  logic [STATE_W-1:0] best_state_i;
  logic               flush_i;
  logic               sm_wr_en_o;
  logic [ADDR_W-1:0]  sm_wr_addr_o;
  logic               sm_rd_en_o;
  logic [ADDR_W-1:0]  sm_rd_addr_o;
  logic               tb_start_o;
  logic [STATE_W-1:0] tb_start_state_o;
  logic               tb_emit_o;
  logic               busy_o;
  logic               done_o;

  modport master (
    input  acs_valid_i, best_state_i, flush_i,
    output acs_ready_o, sm_wr_en_o, sm_wr_addr_o, sm_rd_en_o, sm_rd_addr_o,
           tb_start_o, tb_start_state_o, tb_emit_o, busy_o, done_o
  );

  modport slave (
    output acs_valid_i, best_state_i, flush_i,
    input  acs_ready_o, sm_wr_en_o, sm_wr_addr_o, sm_rd_en_o, sm_rd_addr_o,
           tb_start_o, tb_start_state_o, tb_emit_o, busy_o, done_o
  );
endinterface

// File: rtl/tb_addr_ctr.sv
// Modulo-MEM survivor memory pointer with synchronous load and up/down stepping.
// Load has priority over stepping.
module tb_addr_ctr
  import viterbi_pkg::*;
#(
  parameter int unsigned MEM    = 24,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ld_val,
  input  logic              en,
  input  logic              down,
  output logic [ADDR_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      if (down)
        cnt <= ADDR_W'(addr_dec(32'(cnt), MEM));
      else if (cnt == ADDR_W'(MEM - 1))
        cnt <= '0;
      else
        cnt <= cnt + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/viterbi_tb_sched.sv
// Traceback scheduler: sequences ACS decision writes into survivor memory and issues
// fixed-length traceback windows (regular and end-of-message flush) to the TBU.
module viterbi_tb_sched
  import viterbi_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned BLOCK = BLOCK_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  viterbi_tb_sched_if.master    bus
);

  localparam int unsigned MEM     = DEPTH + BLOCK;
  localparam int unsigned ADDR_W  = $clog2(MEM);
  localparam int unsigned UNDEC_W = $clog2(MEM + 1);

  sched_state_e       state;
  logic [UNDEC_W-1:0] undec;
  logic [ADDR_W-1:0]  step_left;
  logic [STATE_W-1:0] best_q;
  logic               flush_pend;
  logic               ready_q;
  logic               rd_en_q;
  logic               start_q;
  logic [STATE_W-1:0] start_state_q;
  logic               emit_q;
  logic               done_q;

  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               wr;
  logic               last_step;
  logic               fill_full;
  logic [UNDEC_W-1:0] p_flush;
  logic               go_flush_after;
  logic               rd_ld;
  logic [ADDR_W-1:0]  rd_ld_val;
  logic               wr_clr;

  assign wr             = bus.acs_valid_i & ready_q;
  assign last_step      = (step_left == '0);
  assign fill_full      = wr && (undec == UNDEC_W'(MEM - 1));
  assign p_flush        = undec + UNDEC_W'(wr);
  assign go_flush_after = (state == S_TRACE) && last_step && (flush_pend || bus.flush_i);
  assign rd_ld          = ((state == S_FILL) && (fill_full || (bus.flush_i && p_flush != '0)))
                          || go_flush_after;
  // A write in the triggering cycle is the newest entry, so the trace starts on it.
  assign rd_ld_val      = wr ? wr_ptr : ADDR_W'(addr_dec(32'(wr_ptr), MEM));
  assign wr_clr         = (state == S_FLUSH) && last_step;

  tb_addr_ctr #(.MEM(MEM), .ADDR_W(ADDR_W)) u_wr_ptr (
    .clk    (clk),
    .rst    (rst),
    .ld     (wr_clr),
    .ld_val ('0),
    .en     (wr),
    .down   (1'b0),
    .cnt    (wr_ptr)
  );

  tb_addr_ctr #(.MEM(MEM), .ADDR_W(ADDR_W)) u_rd_ptr (
    .clk    (clk),
    .rst    (rst),
    .ld     (rd_ld),
    .ld_val (rd_ld_val),
    .en     ((state != S_FILL) && !last_step),
    .down   (1'b1),
    .cnt    (rd_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_FILL;
      undec         <= '0;
      step_left     <= '0;
      best_q        <= '0;
      flush_pend    <= 1'b0;
      ready_q       <= 1'b1;
      rd_en_q       <= 1'b0;
      start_q       <= 1'b0;
      start_state_q <= '0;
      emit_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      start_q <= 1'b0;
      case (state)
        S_FILL: begin
          if (wr) begin
            best_q <= bus.best_state_i;
            undec  <= undec + UNDEC_W'(1);
          end
          if (fill_full) begin
            state         <= S_TRACE;
            ready_q       <= 1'b0;
            rd_en_q       <= 1'b1;
            start_q       <= 1'b1;
            start_state_q <= bus.best_state_i;
            emit_q        <= (MEM - 1 < BLOCK);
            step_left     <= ADDR_W'(MEM - 1);
            flush_pend    <= bus.flush_i;
          end else if (bus.flush_i) begin
            if (p_flush == '0) begin
              done_q <= 1'b1;
            end else begin
              state         <= S_FLUSH;
              ready_q       <= 1'b0;
              rd_en_q       <= 1'b1;
              start_q       <= 1'b1;
              start_state_q <= '0;
              emit_q        <= 1'b1;
              step_left     <= ADDR_W'(p_flush - UNDEC_W'(1));
            end
          end
        end
        S_TRACE: begin
          if (bus.flush_i)
            flush_pend <= 1'b1;
          if (!last_step) begin
            step_left <= step_left - ADDR_W'(1);
            // Only the oldest BLOCK steps of the window are decoded output.
            emit_q    <= (step_left <= ADDR_W'(BLOCK));
          end else begin
            undec <= UNDEC_W'(DEPTH);
            if (flush_pend || bus.flush_i) begin
              state         <= S_FLUSH;
              flush_pend    <= 1'b0;
              start_q       <= 1'b1;
              start_state_q <= '0;
              emit_q        <= 1'b1;
              step_left     <= ADDR_W'(DEPTH - 1);
            end else begin
              state   <= S_FILL;
              ready_q <= 1'b1;
              rd_en_q <= 1'b0;
              emit_q  <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          if (!last_step) begin
            step_left <= step_left - ADDR_W'(1);
            emit_q    <= 1'b1;
          end else begin
            state   <= S_FILL;
            undec   <= '0;
            ready_q <= 1'b1;
            rd_en_q <= 1'b0;
            emit_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  assign bus.acs_ready_o      = ready_q;
  assign bus.sm_wr_en_o       = wr;
  assign bus.sm_wr_addr_o     = wr_ptr;
  assign bus.sm_rd_en_o       = rd_en_q;
  assign bus.sm_rd_addr_o     = rd_ptr;
  assign bus.tb_start_o       = start_q;
  assign bus.tb_start_state_o = start_state_q;
  assign bus.tb_emit_o        = emit_q;
  assign bus.busy_o           = rd_en_q;
  assign bus.done_o           = done_q;

endmodule

// File: tb/tb_viterbi_tb_sched.sv
// Scoreboard bench for viterbi_tb_sched: a list-of-written-addresses model predicts
// writes, traceback reads and done pulses with their cycle numbers; a monitor checks them.
module tb_viterbi_tb_sched;
  import viterbi_pkg::*;

  localparam int DEPTH = 16;
  localparam int BLOCK = 8;
  localparam int MEM   = 24;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  viterbi_tb_sched_if #(.ADDR_W(AW)) bus ();

  viterbi_tb_sched #(.DEPTH(DEPTH), .BLOCK(BLOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] addr;
    logic          start;
    logic [1:0]    ss;
    logic          emit;
  } rd_t;

  typedef struct {
    int            c;
    logic [AW-1:0] addr;
  } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  done_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  int         hist[$];
  int         next_addr = 0;
  int         stall_end = 0;
  bit         can_pend  = 0;
  logic [1:0] last_best = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endfunction

  // Queue one traceback over the current contents of hist, newest entry first.
  function automatic void sched_reads(input int start_c, input bit flush_mode, input logic [1:0] ss);
    int  n;
    rd_t r;
    n = hist.size();
    for (int i = 0; i < n; i++) begin
      r.c     = start_c + i;
      r.addr  = AW'(hist[n-1-i]);
      r.start = (i == 0);
      r.ss    = ss;
      r.emit  = flush_mode ? 1'b1 : (i >= DEPTH);
      rd_q.push_back(r);
    end
  endfunction

  function automatic void add_flush();
    sched_reads(stall_end + 1, 1'b1, 2'd0);
    stall_end = stall_end + hist.size();
    done_q.push_back(stall_end + 1);
    hist.delete();
    next_addr = 0;
    can_pend  = 0;
  endfunction

  task automatic drive_cycle(input bit valid, input bit flush_req, input logic [1:0] best);
    int  c;
    bit  exp_ready;
    bit  wr;
    bit  flush;
    int  p;
    wr_t w;
    @(posedge clk);
    #1;
    c = cyc;
    exp_ready = (c > stall_end);
    check("acs_ready", 64'(bus.acs_ready_o), 64'(exp_ready));
    wr    = valid && exp_ready;
    p     = hist.size() + (wr ? 1 : 0);
    flush = flush_req;
    if (exp_ready && flush && (p % BLOCK != 0)) flush = 0;
    bus.acs_valid_i  = valid;
    bus.flush_i      = flush;
    bus.best_state_i = best;
    if (wr) begin
      w.c  = c;
      w.addr = AW'(next_addr);
      wr_q.push_back(w);
      hist.push_back(next_addr);
      next_addr = (next_addr + 1) % MEM;
      last_best = best;
    end
    if (exp_ready) begin
      if (hist.size() == MEM) begin
        sched_reads(c + 1, 1'b0, last_best);
        stall_end = c + MEM;
        repeat (BLOCK) void'(hist.pop_front());
        can_pend = 1;
        if (flush) add_flush();
      end else if (flush) begin
        if (hist.size() == 0) begin
          done_q.push_back(c + 1);
        end else begin
          stall_end = c;
          add_flush();
        end
      end
    end else if (flush && can_pend) begin
      add_flush();
    end
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.acs_valid_i  = 1'b0;
    bus.flush_i      = 1'b0;
    bus.best_state_i = '0;
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    hist.delete();
    next_addr = 0;
    can_pend  = 0;
    #1;
    check("reset_outputs",
          64'({bus.acs_ready_o, bus.sm_wr_en_o, bus.sm_wr_addr_o, bus.sm_rd_en_o, bus.sm_rd_addr_o,
               bus.tb_start_o, bus.tb_start_state_o, bus.tb_emit_o, bus.busy_o, bus.done_o}),
          64'h40000);
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
    stall_end = cyc;
  endtask

  rd_t mr;
  wr_t mw;
  int  md;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sm_rd_en_o) begin
        if (rd_q.size() == 0) begin
          n_chk++;
          $display("FAIL rd_unexpected at cycle %0d: got read of addr %0d, expected none", cyc, bus.sm_rd_addr_o);
        end else begin
          mr = rd_q.pop_front();
          check("rd", {22'(cyc), bus.sm_rd_addr_o, bus.tb_start_o, bus.tb_start_state_o, bus.tb_emit_o, bus.busy_o},
                      {22'(mr.c), mr.addr, mr.start, mr.ss, mr.emit, 1'b1});
        end
      end else begin
        check("idle", 64'({bus.tb_start_o, bus.tb_emit_o, bus.busy_o}), 64'(3'b000));
      end
      if (bus.sm_wr_en_o) begin
        if (wr_q.size() == 0) begin
          n_chk++;
          $display("FAIL wr_unexpected at cycle %0d: got write to addr %0d, expected none", cyc, bus.sm_wr_addr_o);
        end else begin
          mw = wr_q.pop_front();
          check("wr", {32'(cyc), bus.sm_wr_addr_o}, {32'(mw.c), mw.addr});
        end
      end
      if (bus.done_o) begin
        if (done_q.size() == 0) begin
          n_chk++;
          $display("FAIL done_unexpected at cycle %0d: got done pulse, expected none", cyc);
        end else begin
          md = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(md));
        end
      end
    end
  end

  initial begin
    bus.acs_valid_i  = 1'b0;
    bus.flush_i      = 1'b0;
    bus.best_state_i = '0;
    do_reset(2);

    // reset in the middle of filling; the next write must land at address 0
    repeat (5) drive_cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)));
    do_reset(1);

    // full window with best state 2 on the last write, valid held through the trace,
    // then a second window that wraps the survivor memory
    for (int i = 0; i < 24; i++)
      drive_cycle(1'b1, 1'b0, (i == 23) ? 2'd2 : 2'($urandom_range(0, 3)));
    repeat (60) drive_cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)));

    // short message: 8 writes then flush, then a write after done
    do_reset(1);
    repeat (8) drive_cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)));
    drive_cycle(1'b0, 1'b1, 2'd0);
    repeat (12) drive_cycle(1'b0, 1'b0, 2'd0);
    drive_cycle(1'b1, 1'b0, 2'd1);

    // flush during a regular trace, then flush with nothing undecoded
    do_reset(1);
    repeat (24) drive_cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)));
    repeat (5) drive_cycle(1'b0, 1'b0, 2'd0);
    drive_cycle(1'b0, 1'b1, 2'd0);
    repeat (40) drive_cycle(1'b0, 1'b0, 2'd0);
    drive_cycle(1'b0, 1'b1, 2'd0);
    repeat (3) drive_cycle(1'b0, 1'b0, 2'd0);

    // random traffic with occasional flushes and resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 2)
        do_reset(1 + int'($urandom_range(0, 2)));
      else
        drive_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)));
    end

    repeat (60) drive_cycle(1'b0, 1'b0, 2'd0);
    #2;
    check("rd_q_drained", 64'(rd_q.size()), 64'(0));
    check("wr_q_drained", 64'(wr_q.size()), 64'(0));
    check("done_q_drained", 64'(done_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/viterbi_tb_sched.md
# viterbi_tb_sched

Traceback scheduler for the Viterbi decoder. It sits between the ACS unit and the TBU and owns the survivor-memory address space. It sequences ACS decision writes, triggers fixed-length traceback windows, and tells the TBU which traceback steps produce decoded bits. It stalls the ACS during traceback and runs a final terminated traceback on end-of-message, so the downstream SIPO always receives complete decoded blocks.

## Interface
- DEPTH, 16: traceback convergence depth; steps traced but not emitted.
- BLOCK, 8: decoded bits emitted per regular traceback; matches the SIPO byte.
- STATE_W, 2: trellis state width (K=3, 4 states).
- MEM (localparam) = DEPTH+BLOCK: survivor memory entries. ADDR_W (localparam) = clog2(MEM).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- acs_valid_i  in  1  ACS decision vector available this cycle
- acs_ready_o  out  1  scheduler accepts a decision (write) this cycle
- best_state_i  in  STATE_W  minimum-metric state; sampled with each accepted write
- flush_i  in  1  end-of-message pulse
- sm_wr_en_o  out  1  survivor memory write strobe (= acs_valid_i & acs_ready_o)
- sm_wr_addr_o  out  ADDR_W  write address
- sm_rd_en_o  out  1  survivor memory read strobe, one per traceback step
- sm_rd_addr_o  out  ADDR_W  read address
- tb_start_o  out  1  1-cycle pulse on the first read of a traceback
- tb_start_state_o  out  STATE_W  traceback start state, valid with tb_start_o
- tb_emit_o  out  1  current step's decoded bit goes to SIPO
- busy_o  out  1  traceback in progress
- done_o  out  1  1-cycle pulse when flush processing completes

## Operation
- States are S_FILL, S_TRACE and S_FLUSH.
- S_FILL:
  - acs_ready_o=1. Each accepted write goes to wr_ptr, then wr_ptr advances with wrap at MEM-1 → 0.
  - undec (undecoded count, 0..MEM) increments on each write. best_state_i is latched.
  - When undec reaches MEM, go to S_TRACE.
- S_TRACE:
  - acs_ready_o=0. Issues MEM reads, starting at wr_ptr-1 and descending with wrap 0 → MEM-1.
  - Start state is the latched best state.
  - tb_emit_o=0 for the first DEPTH steps and 1 for the last BLOCK steps.
  - At the end, undec=DEPTH. Return to S_FILL, or to S_FLUSH if flush is pending.
- Flush:
  - flush_i in S_FILL with undec=P>0 → S_FLUSH. flush_i in S_TRACE sets flush_pend, which is cleared on entering S_FLUSH.
  - S_FLUSH issues P reads descending from wr_ptr-1, start state 0 (zero-tailed trellis). tb_emit_o=1 on every step.
  - At the end: done_o pulse, undec=0, wr_ptr=0, return to S_FILL.
  - If P=0 at flush, done_o pulses next cycle and no reads are issued.
  - P must be a multiple of BLOCK; tail padding is the encoder side's duty. The scheduler does not check this.
- Same-cycle events:
  - acs write and flush_i together in S_FILL: the write counts toward P.
  - acs write completing undec=MEM together with flush_i: the regular trace runs, then the flush trace of DEPTH steps.
- acs_valid_i while acs_ready_o=0 is not written. Upstream holds its data.
- Emitted bit order is newest-to-oldest within a window. Reordering for the SIPO is the TBU's job.

## Timing
- Reset values: acs_ready_o=1. All other outputs are 0, wr_ptr=0, undec=0, flush_pend=0, state S_FILL.
- Entering a trace:
  - The trace starts the cycle after the triggering write/flush.
  - The first read cycle carries tb_start_o=1 and sm_rd_en_o=1.
  - Reads are back-to-back, one per cycle. A regular trace is MEM cycles; a flush trace is P cycles.
- Signal alignment:
  - tb_emit_o, tb_start_o and busy_o are aligned with sm_rd_en_o.
  - Survivor memory read latency (1 cycle) is absorbed by the TBU.
- Cycle boundaries:
  - acs_ready_o drops the cycle after the triggering write.
  - acs_ready_o rises the cycle after the last read.
  - done_o coincides with that first ready cycle.
- Reset mid-operation aborts the trace immediately: all outputs go to their reset values and stored decisions are abandoned.

## Structure
- viterbi_pkg holds: scheduler state encoding; STATE_W; default DEPTH/BLOCK; an addr_dec(a) wrap helper function.
- Sub-module tb_addr_ctr holds the modulo-MEM up/down pointer with load, shared by the write pointer and the read pointer.
- The FSM, undec counter and step counter stay in viterbi_tb_sched.

## Test plan
All scenarios use DEPTH=16, BLOCK=8, MEM=24.
1. Reset asserted mid-FILL → next edge: acs_ready_o=1, all other outputs 0, the next write lands at addr 0.
2. 24 consecutive writes, best_state_i=2 on the last → trace of 24 cycles; tb_start_state_o=2; reads 23..0; tb_emit_o high on addrs 7..0; acs_ready_o low exactly 24 cycles.
3. Continue from scenario 2 with 8 writes (addrs 0..7) → trace reads 7..0 then 23..8 (wrap); emit on addrs 15..8.
4. From reset, 8 writes then flush_i → 8-cycle trace, reads 7..0, start state 0, tb_emit_o all 1; done_o one cycle after the last read; next write at addr 0.
5. flush_i during a regular trace → flush trace of 16 reads follows immediately, all emitted, then done_o. Separately, flush_i with undec=0 → done_o next cycle, no reads.
6. acs_valid_i held high through a trace → no sm_wr_en_o during the trace, and no decisions lost afterwards (write addresses continuous).
